// File: rtl/key_unlock_loader.sv
// Serial key loader: shifts a KEY_W-bit key in MSB first, compares it to GOLDEN,
// holds key_out high while unlocked and enforces a timed lockout after MAX_FAIL misses.
module key_unlock_loader #(
   parameter int unsigned      KEY_W    = 8,
   parameter logic [KEY_W-1:0] GOLDEN   = 8'hA5,
   parameter int unsigned      MAX_FAIL = 4,
   parameter int unsigned      LOCK_CYC = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       key_valid,
   input  logic       key_bit,
   input  logic       relock,
   output logic       key_ready,
   output logic       key_out,
   output logic       unlocked,
   output logic       lockout,
   output logic       busy,
   output logic [2:0] fail_cnt,
   output logic [2:0] state_dbg
);

   // Handshake: a key bit is taken on a rising edge where key_valid && key_ready;
   // key_valid low in SHIFT simply stalls, there is no timeout.

   localparam int unsigned        CNT_W     = $clog2(KEY_W + 1);
   localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(KEY_W - 1);
   localparam logic [2:0]         FAIL_MAX  = 3'(MAX_FAIL);
   localparam logic [7:0]         LOCK_INIT = 8'(LOCK_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SHIFT    = 3'd1,
      S_CHECK    = 3'd2,
      S_UNLOCKED = 3'd3,
      S_LOCKOUT  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [KEY_W-1:0]   sr_q, sr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         timer_q, timer_d;
   logic [2:0]         fail_q, fail_d;
   logic               key_ready_q, key_ready_d;
   logic               key_out_q, key_out_d;
   logic               unlocked_q, unlocked_d;
   logic               lockout_q, lockout_d;
   logic               busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      timer_d = timer_q;
      fail_d  = fail_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SHIFT;
               sr_d    = '0;
               cnt_d   = '0;
            end
         end
         S_SHIFT: begin
            if (key_valid && key_ready_q) begin
               sr_d  = {sr_q[KEY_W-2:0], key_bit};
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_BIT) state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (sr_q == GOLDEN) begin
               state_d = S_UNLOCKED;
               fail_d  = '0;
            end else begin
               fail_d = fail_q + 3'd1;
               if (fail_d == FAIL_MAX) begin
                  state_d = S_LOCKOUT;
                  timer_d = LOCK_INIT;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         // relock wins over start here because start is only looked at in IDLE
         S_UNLOCKED: begin
            if (relock) state_d = S_IDLE;
         end
         S_LOCKOUT: begin
            if (timer_q == 8'd0) begin
               state_d = S_IDLE;
               fail_d  = '0;
            end else begin
               timer_d = timer_q - 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they register alongside it.
      key_ready_d = (state_d == S_SHIFT);
      key_out_d   = (state_d == S_UNLOCKED);
      unlocked_d  = (state_d == S_UNLOCKED);
      lockout_d   = (state_d == S_LOCKOUT);
      busy_d      = (state_d == S_SHIFT) || (state_d == S_CHECK);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sr_q        <= '0;
         cnt_q       <= '0;
         timer_q     <= '0;
         fail_q      <= '0;
         key_ready_q <= 1'b0;
         key_out_q   <= 1'b0;
         unlocked_q  <= 1'b0;
         lockout_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         timer_q     <= timer_d;
         fail_q      <= fail_d;
         key_ready_q <= key_ready_d;
         key_out_q   <= key_out_d;
         unlocked_q  <= unlocked_d;
         lockout_q   <= lockout_d;
         busy_q      <= busy_d;
      end
   end

   assign key_ready = key_ready_q;
   assign key_out   = key_out_q;
   assign unlocked  = unlocked_q;
   assign lockout   = lockout_q;
   assign busy      = busy_q;
   assign fail_cnt  = fail_q;
   assign state_dbg = state_q;

endmodule

// File: doc/key_unlock_loader.md
KEY_UNLOCK_LOADER -- requirements
Module: key_unlock_loader

Interface
REQ-001 Parameter KEY_W, default 8, key length in bits (2..32).
REQ-002 Parameter GOLDEN, default 8'hA5, correct key value, KEY_W bits.
REQ-003 Parameter MAX_FAIL, default 4, failed attempts before lockout (1..7).
REQ-004 Parameter LOCK_CYC, default 16, lockout duration in clk cycles (1..255).
REQ-005 clk  input  1  clock; all state updates on rising edge, so key_out is stable at the consumer's falling-edge sample.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  single-cycle request to begin a key load.
REQ-008 key_valid  input  1  key_bit qualifier.
REQ-009 key_bit  input  1  serial key data, MSB first.
REQ-010 relock  input  1  single-cycle request to withdraw an accepted key.
REQ-011 key_ready  output  1  loader accepts a bit this cycle.
REQ-012 key_out  output  1  key bit driven to the locked FSM's key input.
REQ-013 unlocked  output  1  a correct key is held.
REQ-014 lockout  output  1  lockout period active.
REQ-015 busy  output  1  high in SHIFT or CHECK.
REQ-016 fail_cnt  output  3  consecutive failed attempts.

Function
REQ-017 The FSM SHALL have the states IDLE, SHIFT, CHECK, UNLOCKED, LOCKOUT, with state and all outputs registered.
REQ-018 In IDLE, start=1 SHALL move the FSM to SHIFT and clear the shift register and the bit counter; start SHALL be ignored in every other state.
REQ-019 In SHIFT, key_ready SHALL be 1; on key_valid&key_ready the shift register SHALL load {sr[KEY_W-2:0],key_bit} and the bit counter SHALL increment.
REQ-020 key_valid=0 in SHIFT SHALL stall with no state change and no timeout.
REQ-021 Acceptance of the KEY_W-th bit SHALL move the FSM to CHECK; key_ready SHALL be 0 from the following cycle.
REQ-022 CHECK SHALL last exactly one cycle.
REQ-023 In CHECK with sr==GOLDEN, the FSM SHALL go to UNLOCKED and clear fail_cnt.
REQ-024 In CHECK with sr!=GOLDEN, fail_cnt SHALL increment; if the new value equals MAX_FAIL the FSM SHALL go to LOCKOUT, otherwise to IDLE.
REQ-025 In UNLOCKED, key_out and unlocked SHALL be 1; in all other states both SHALL be 0.
REQ-026 relock=1 in UNLOCKED SHALL return the FSM to IDLE next cycle; relock in any other state SHALL be ignored.
REQ-027 relock and start asserted together in UNLOCKED: relock SHALL take effect and start SHALL be ignored.
REQ-028 On entering LOCKOUT, lockout SHALL be 1 and a timer SHALL load LOCK_CYC-1 and decrement each cycle.
REQ-029 When the LOCKOUT timer reaches 0, the FSM SHALL go to IDLE, lockout SHALL drop and fail_cnt SHALL clear, so lockout is high for exactly LOCK_CYC cycles.
REQ-030 fail_cnt SHALL never exceed MAX_FAIL.
REQ-031 A successful unlock SHALL clear fail_cnt; relock SHALL NOT change fail_cnt.
REQ-032 busy SHALL be 1 exactly in SHIFT and CHECK.

Reset
REQ-033 rst=1 SHALL force IDLE immediately, regardless of clk.
REQ-034 rst=1 SHALL set key_ready, key_out, unlocked, lockout, busy and fail_cnt to 0.
REQ-035 rst=1 SHALL clear the shift register, bit counter and LOCKOUT timer.
REQ-036 rst asserted mid-SHIFT or mid-LOCKOUT SHALL discard all progress, and the fail history SHALL NOT survive reset.

Verification
REQ-037 Correct load: rst, start, 8 consecutive valid bits of 8'hA5 -> key_ready=0 after the 8th bit, one CHECK cycle, then key_out=1, unlocked=1, fail_cnt=0.
REQ-038 Wrong key: load 8'h5A -> returns to IDLE, fail_cnt=1, key_out=0, lockout=0.
REQ-039 Lockout: four wrong loads -> lockout=1 for exactly 16 cycles, start ignored during that period, then IDLE with fail_cnt=0; next load of 8'hA5 -> unlocked.
REQ-040 Stall: load 8'hA5 with key_valid low on alternate cycles -> same result as REQ-037, busy high throughout SHIFT and CHECK.
REQ-041 Reset mid-operation: rst after 4 accepted bits -> all outputs 0 immediately; fresh load of 8'hA5 -> unlocked=1.
REQ-042 Relock priority: in UNLOCKED, relock=1 and start=1 in the same cycle -> IDLE next cycle, key_out=0, busy=0, fail_cnt unchanged.
